alu_datapath_pipe: RTL and testbench
====================================

// Module: alu_datapath_pipe
// PURPOSE
// - Parametrised successor ALU datapath: NUM_REGS x WIDTH register file, two operand selects, immediate mux,
//   ALU with flags register, registered execute stage and a multi-cycle shift-add multiplier.
// - Sits between instruction decode (valid/ready issue port) and the register-load path (ext write port).
// - Adds issue handshake, writeback forwarding and a status flag register.
// PARAMETERS
// WIDTH     16  datapath / register width (>=4)
// NUM_REGS  16  register count (power of 2, >=2); SEL_W = $clog2(NUM_REGS) localparam
// MUL_EN    1   1: MUL implemented; 0: MUL decodes as NOP
// PORTS
// clk          in   1      single clock, rising edge
// reset        in   1      synchronous, active-high
// in_valid     in   1      issue request
// in_ready     out  1      datapath can accept issue this cycle
// opcode       in   4      operation (see BEHAVIOUR)
// ra_sel       in   SEL_W  operand A register
// rb_sel       in   SEL_W  operand B register
// rd_sel       in   SEL_W  destination register
// use_imm      in   1      1: operand B = imm, rb_sel ignored
// imm          in   WIDTH  immediate operand
// ext_wr_en    in   1      external register load
// ext_wr_sel   in   SEL_W  external load target
// ext_wr_data  in   WIDTH  external load data
// out_valid    out  1      one-cycle pulse: result/flags updated
// result       out  WIDTH  last completed result (held between pulses)
// flags        out  4      {V,C,N,Z}, registered
// BEHAVIOUR
// - Reset: all registers, result, flags = 0; out_valid = 0; in_ready = 1; FSM -> IDLE; aborts any MUL in flight.
// - Handshake: issue accepted on edge where in_valid && in_ready; operands, opcode, rd latched into EX stage.
// - Opcodes: 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 SHL, 7 SHR, 8 ASR, 9 MOV (B), 10 CMP (SUB, flags only,
//   no writeback), 11 MUL (low WIDTH bits of A*B unsigned), 12-15 NOP (no write, flags unchanged, out_valid still pulses).
// - Shift amount = B[SEL_AMT-1:0], SEL_AMT = $clog2(WIDTH); amount 0 passes A, C=0.
// - Flags: Z = result==0, N = result[WIDTH-1]. ADD: C carry-out, V signed overflow. SUB/CMP: C = 1 when A>=B unsigned
//   (no borrow), V signed overflow. Logic/MOV: C=V=0. Shifts: C = last bit shifted out, V=0. MUL: C = upper half nonzero, V=0.
// - FSM IDLE/EXEC/MUL. IDLE: accept -> EXEC (MUL -> MUL, counter = WIDTH). EXEC: writeback rd, load result/flags,
//   out_valid=1; in_ready stays 1 so a new issue is accepted in the same cycle (EXEC->EXEC, 1 op/cycle throughput).
//   MUL: in_ready=0, one shift-add step per cycle; after WIDTH steps writeback+out_valid, -> IDLE.
// - Latency: single-cycle op accepted at edge N -> out_valid high in cycle after edge N+1; MUL -> after edge N+WIDTH.
// - Forwarding: issue whose ra/rb equals EX-stage rd of a writing op uses EX ALU output, not stale register value.
// - Ext write: written at edge when ext_wr_en; same-edge collision with pipeline writeback to same reg -> pipeline wins;
//   different regs -> both written. Forwarding also covers ext_wr_data to matching ra/rb in same cycle (pipeline has priority).
// - Arithmetic modulo 2^WIDTH; no exceptions. Flags change only on out_valid of non-NOP ops.
// STRUCTURE
// - Package alu_dp_pkg: opcode localparams, flag bit indices (Z=0,N=1,C=2,V=3), FSM state enum.
// - Sub-module reg_file: NUM_REGS x WIDTH, 2 async read ports, 2 sync write ports with port-0 priority on collision.
// - ALU combinational logic and multiplier FSM remain in this module.
// TESTING
// - reset mid-MUL (WIDTH=16, 5 cycles in) -> regs/result/flags=0, in_ready=1 next cycle, no out_valid.
// - ext load R1=0x7FFF, R2=0x0001; ADD R3=R1+R2 -> result 0x8000, flags V=1,N=1,C=0,Z=0.
// - SUB R4=R2-R2 -> 0x0000, Z=1,C=1; CMP R1,R2 -> flags N=0,C=1, R-file unchanged.
// - back-to-back ADD R5=R1+R2 then ADD R6=R5+R2 -> R6=0x8001 (forwarding), out_valid two consecutive cycles.
// - MUL R7=0x0300*0x0100 -> in_ready low 16 cycles, result 0x0000, C=1,Z=1; issue held during MUL accepted after.
// - SHL R1 by imm 1 -> 0xFFFE, C=0; ext write and writeback to same reg same edge -> writeback value stored.

Source files
------------

// File: rtl/alu_dp_pkg.sv
// Shared definitions for the ALU datapath: opcode encodings, flag bit positions,
// control FSM states and opcode classification helpers.
package alu_dp_pkg;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_OR  = 4'd3;
   localparam logic [3:0] OP_XOR = 4'd4;
   localparam logic [3:0] OP_NOT = 4'd5;
   localparam logic [3:0] OP_SHL = 4'd6;
   localparam logic [3:0] OP_SHR = 4'd7;
   localparam logic [3:0] OP_ASR = 4'd8;
   localparam logic [3:0] OP_MOV = 4'd9;
   localparam logic [3:0] OP_CMP = 4'd10;
   localparam logic [3:0] OP_MUL = 4'd11;

   localparam int FLAG_Z = 0;
   localparam int FLAG_N = 1;
   localparam int FLAG_C = 2;
   localparam int FLAG_V = 3;

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXEC,
      S_MUL
   } state_e;

   // Opcodes 12-15 (and MUL when the multiplier is not built) behave as NOP.
   function automatic logic op_writes(input logic [3:0] op, input bit mul_en);
      return (op <= OP_MOV) || (mul_en && (op == OP_MUL));
   endfunction

   function automatic logic op_sets_flags(input logic [3:0] op, input bit mul_en);
      return op_writes(op, mul_en) || (op == OP_CMP);
   endfunction

endpackage

// File: rtl/alu_datapath_pipe_reg_file.sv
// Register file: NUM_REGS x WIDTH, two asynchronous read ports and two synchronous
// write ports; port 0 wins when both ports target the same register on one edge.
module reg_file
   import alu_dp_pkg::*;
#(
   parameter int  WIDTH    = 16,
   parameter int  NUM_REGS = 16,
   localparam int SEL_W    = $clog2(NUM_REGS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [SEL_W-1:0] rd_a_sel,
   output logic [WIDTH-1:0] rd_a_data,
   input  logic [SEL_W-1:0] rd_b_sel,
   output logic [WIDTH-1:0] rd_b_data,
   input  logic             wr0_en,
   input  logic [SEL_W-1:0] wr0_sel,
   input  logic [WIDTH-1:0] wr0_data,
   input  logic             wr1_en,
   input  logic [SEL_W-1:0] wr1_sel,
   input  logic [WIDTH-1:0] wr1_data
);

   logic [WIDTH-1:0] mem_q [NUM_REGS];
   logic [WIDTH-1:0] mem_d [NUM_REGS];

   assign rd_a_data = mem_q[rd_a_sel];
   assign rd_b_data = mem_q[rd_b_sel];

   // NOTE: a combinational block must give every output a value on every path;
   // copying the current state first is what keeps latches from being inferred.
   always_comb begin
      mem_d = mem_q;
      if (wr1_en) mem_d[wr1_sel] = wr1_data;
      if (wr0_en) mem_d[wr0_sel] = wr0_data;
   end

   // NOTE: this array is architectural state that must read as zero after reset,
   // so it is built from resettable flops rather than an inferred RAM macro.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
      end else begin
         mem_q <= mem_d;
      end
   end

endmodule

// File: rtl/alu_datapath_pipe.sv
// ALU datapath: issue handshake, operand forwarding, registered execute stage,
// flags register and a WIDTH-step shift-add multiplier, around a two-write-port regfile.
module alu_datapath_pipe
   import alu_dp_pkg::*;
#(
   parameter int  WIDTH    = 16,
   parameter int  NUM_REGS = 16,
   parameter bit  MUL_EN   = 1'b1,
   localparam int SEL_W    = $clog2(NUM_REGS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       opcode,
   input  logic [SEL_W-1:0] ra_sel,
   input  logic [SEL_W-1:0] rb_sel,
   input  logic [SEL_W-1:0] rd_sel,
   input  logic             use_imm,
   input  logic [WIDTH-1:0] imm,
   input  logic             ext_wr_en,
   input  logic [SEL_W-1:0] ext_wr_sel,
   input  logic [WIDTH-1:0] ext_wr_data,
   output logic             out_valid,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags
);

   localparam int SEL_AMT = $clog2(WIDTH);
   localparam int CNT_W   = $clog2(WIDTH + 1);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [3:0]         ex_op_q, ex_op_d;
   logic [WIDTH-1:0]   ex_a_q, ex_a_d;
   logic [WIDTH-1:0]   ex_b_q, ex_b_d;
   logic [SEL_W-1:0]   ex_rd_q, ex_rd_d;
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic [3:0]         flags_q, flags_d;
   logic               out_valid_q, out_valid_d;

   logic [WIDTH-1:0]   rf_a, rf_b, op_a, op_b;
   logic               wb_en;
   logic [SEL_W-1:0]   wb_sel;
   logic [WIDTH-1:0]   wb_data;
   logic               issue_fire, ex_fwd;

   logic [WIDTH:0]     add_w, sub_w, shl_w, shr_w, asr_w;
   logic [SEL_AMT-1:0] sh_amt;
   logic [WIDTH-1:0]   alu_res;
   logic               alu_c, alu_v;
   logic [3:0]         alu_flags;
   logic [2*WIDTH-1:0] acc_step;
   logic [3:0]         mul_flags;

   reg_file #(
      .WIDTH    (WIDTH),
      .NUM_REGS (NUM_REGS)
   ) u_reg_file (
      .clk       (clk),
      .reset     (reset),
      .rd_a_sel  (ra_sel),
      .rd_a_data (rf_a),
      .rd_b_sel  (rb_sel),
      .rd_b_data (rf_b),
      .wr0_en    (wb_en),
      .wr0_sel   (wb_sel),
      .wr0_data  (wb_data),
      .wr1_en    (ext_wr_en),
      .wr1_sel   (ext_wr_sel),
      .wr1_data  (ext_wr_data)
   );

   assign in_ready   = (state_q != S_MUL);
   assign issue_fire = in_valid && in_ready;
   assign out_valid  = out_valid_q;
   assign result     = result_q;
   assign flags      = flags_q;

   // Execute-stage ALU, evaluated on the latched operands.
   always_comb begin
      add_w  = {1'b0, ex_a_q} + {1'b0, ex_b_q};
      sub_w  = {1'b0, ex_a_q} - {1'b0, ex_b_q};
      sh_amt = ex_b_q[SEL_AMT-1:0];
      // The extra bit catches the last bit shifted out; amount 0 leaves it clear.
      shl_w  = {1'b0, ex_a_q} << sh_amt;
      shr_w  = {ex_a_q, 1'b0} >> sh_amt;
      asr_w  = $signed({ex_a_q, 1'b0}) >>> sh_amt;
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (ex_op_q)
         OP_ADD: begin
            alu_res = add_w[WIDTH-1:0];
            alu_c   = add_w[WIDTH];
            alu_v   = (ex_a_q[WIDTH-1] == ex_b_q[WIDTH-1]) && (alu_res[WIDTH-1] != ex_a_q[WIDTH-1]);
         end
         OP_SUB, OP_CMP: begin
            alu_res = sub_w[WIDTH-1:0];
            alu_c   = ~sub_w[WIDTH];
            alu_v   = (ex_a_q[WIDTH-1] != ex_b_q[WIDTH-1]) && (alu_res[WIDTH-1] != ex_a_q[WIDTH-1]);
         end
         OP_AND: alu_res = ex_a_q & ex_b_q;
         OP_OR:  alu_res = ex_a_q | ex_b_q;
         OP_XOR: alu_res = ex_a_q ^ ex_b_q;
         OP_NOT: alu_res = ~ex_a_q;
         OP_SHL: begin
            alu_res = shl_w[WIDTH-1:0];
            alu_c   = shl_w[WIDTH];
         end
         OP_SHR: begin
            alu_res = shr_w[WIDTH:1];
            alu_c   = shr_w[0];
         end
         OP_ASR: begin
            alu_res = asr_w[WIDTH:1];
            alu_c   = asr_w[0];
         end
         OP_MOV: alu_res = ex_b_q;
         default: alu_res = '0;
      endcase
      alu_flags         = '0;
      alu_flags[FLAG_Z] = (alu_res == '0);
      alu_flags[FLAG_N] = alu_res[WIDTH-1];
      alu_flags[FLAG_C] = alu_c;
      alu_flags[FLAG_V] = alu_v;
   end

   always_comb begin
      acc_step          = acc_q + (mplier_q[0] ? mcand_q : '0);
      mul_flags         = '0;
      mul_flags[FLAG_Z] = (acc_step[WIDTH-1:0] == '0);
      mul_flags[FLAG_N] = acc_step[WIDTH-1];
      mul_flags[FLAG_C] = |acc_step[2*WIDTH-1:WIDTH];
   end

   // Operand selection; the in-flight ALU result overrides a same-cycle external load.
   always_comb begin
      ex_fwd = (state_q == S_EXEC) && op_writes(ex_op_q, MUL_EN);
      op_a = rf_a;
      if (ext_wr_en && (ext_wr_sel == ra_sel)) op_a = ext_wr_data;
      if (ex_fwd && (ex_rd_q == ra_sel))       op_a = alu_res;
      op_b = rf_b;
      if (ext_wr_en && (ext_wr_sel == rb_sel)) op_b = ext_wr_data;
      if (ex_fwd && (ex_rd_q == rb_sel))       op_b = alu_res;
      if (use_imm)                             op_b = imm;
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      ex_op_d     = ex_op_q;
      ex_a_d      = ex_a_q;
      ex_b_d      = ex_b_q;
      ex_rd_d     = ex_rd_q;
      mcand_d     = mcand_q;
      acc_d       = acc_q;
      mplier_d    = mplier_q;
      result_d    = result_q;
      flags_d     = flags_q;
      out_valid_d = 1'b0;
      wb_en       = 1'b0;
      wb_sel      = ex_rd_q;
      wb_data     = alu_res;

      case (state_q)
         S_EXEC: begin
            out_valid_d = 1'b1;
            state_d     = S_IDLE;
            if (op_writes(ex_op_q, MUL_EN)) begin
               wb_en    = 1'b1;
               result_d = alu_res;
            end
            if (op_sets_flags(ex_op_q, MUL_EN)) flags_d = alu_flags;
         end
         S_MUL: begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               wb_en       = 1'b1;
               wb_data     = acc_step[WIDTH-1:0];
               result_d    = acc_step[WIDTH-1:0];
               flags_d     = mul_flags;
               out_valid_d = 1'b1;
               state_d     = S_IDLE;
            end
         end
         default: ;
      endcase

      if (issue_fire) begin
         ex_op_d = opcode;
         ex_a_d  = op_a;
         ex_b_d  = op_b;
         ex_rd_d = rd_sel;
         if (MUL_EN && (opcode == OP_MUL)) begin
            state_d  = S_MUL;
            cnt_d    = CNT_W'(WIDTH);
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, op_a};
            mplier_d = op_b;
         end else begin
            state_d = S_EXEC;
         end
      end
   end

   // NOTE: state flops use non-blocking assignments so every register samples
   // its _d value from before the edge, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         ex_op_q     <= '0;
         ex_a_q      <= '0;
         ex_b_q      <= '0;
         ex_rd_q     <= '0;
         mcand_q     <= '0;
         acc_q       <= '0;
         mplier_q    <= '0;
         result_q    <= '0;
         flags_q     <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ex_op_q     <= ex_op_d;
         ex_a_q      <= ex_a_d;
         ex_b_q      <= ex_b_d;
         ex_rd_q     <= ex_rd_d;
         mcand_q     <= mcand_d;
         acc_q       <= acc_d;
         mplier_q    <= mplier_d;
         result_q    <= result_d;
         flags_q     <= flags_d;
         out_valid_q <= out_valid_d;
      end
   end

endmodule

// File: tb/tb_alu_datapath_pipe.sv
// Directed bench for alu_datapath_pipe (WIDTH=16, NUM_REGS=16): hand-computed
// results and {V,C,N,Z} flags, forwarding, MUL stall, write collisions, reset abort.
module tb_alu_datapath_pipe;
   import alu_dp_pkg::*;

   localparam logic [3:0] FV = 4'b1000;
   localparam logic [3:0] FC = 4'b0100;
   localparam logic [3:0] FN = 4'b0010;
   localparam logic [3:0] FZ = 4'b0001;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  opcode = '0;
   logic [3:0]  ra_sel = '0, rb_sel = '0, rd_sel = '0;
   logic        use_imm = 1'b0;
   logic [15:0] imm = '0;
   logic        ext_wr_en = 1'b0;
   logic [3:0]  ext_wr_sel = '0;
   logic [15:0] ext_wr_data = '0;
   logic        out_valid;
   logic [15:0] result;
   logic [3:0]  flags;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   alu_datapath_pipe #(.WIDTH(16), .NUM_REGS(16), .MUL_EN(1'b1)) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .opcode      (opcode),
      .ra_sel      (ra_sel),
      .rb_sel      (rb_sel),
      .rd_sel      (rd_sel),
      .use_imm     (use_imm),
      .imm         (imm),
      .ext_wr_en   (ext_wr_en),
      .ext_wr_sel  (ext_wr_sel),
      .ext_wr_data (ext_wr_data),
      .out_valid   (out_valid),
      .result      (result),
      .flags       (flags)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic ext_load(input logic [3:0] sel, input logic [15:0] data);
      ext_wr_en = 1'b1; ext_wr_sel = sel; ext_wr_data = data;
      tick();
      ext_wr_en = 1'b0;
   endtask

   task automatic drive(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] ra,
                        input logic [3:0] rb, input logic ui, input logic [15:0] im);
      opcode = op; rd_sel = rd; ra_sel = ra; rb_sel = rb; use_imm = ui; imm = im;
      in_valid = 1'b1;
   endtask

   task automatic accept(input string tag);
      int n = 0;
      while (!in_ready && n < 100) begin
         tick();
         n++;
      end
      check({tag, " in_ready"}, 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic expect_out(input string tag, input int exp_lat, input logic chk_res,
                             input logic [15:0] exp_res, input logic [3:0] exp_fl);
      int lat = 0;
      do begin
         tick();
         lat++;
      end while (!out_valid && lat < 40);
      check({tag, " latency"}, 32'(lat), 32'(exp_lat));
      if (chk_res) check({tag, " result"}, 32'(result), 32'(exp_res));
      check({tag, " flags"}, 32'(flags), 32'(exp_fl));
      tick();
      check({tag, " pulse end"}, 32'(out_valid), 32'd0);
   endtask

   task automatic mov_check(input string tag, input logic [3:0] src,
                            input logic [15:0] exp_res, input logic [3:0] exp_fl);
      drive(OP_MOV, 4'd0, 4'd0, src, 1'b0, 16'h0);
      accept(tag);
      expect_out(tag, 1, 1'b1, exp_res, exp_fl);
   endtask

   // ADD rd = R2(=1) + addend; an external write lands on the writeback edge.
   task automatic collide(input string tag, input logic [3:0] rd, input logic [15:0] addend,
                          input logic [3:0] esel, input logic [15:0] edata);
      drive(OP_ADD, rd, 4'd2, 4'd0, 1'b1, addend);
      accept(tag);
      ext_wr_en = 1'b1; ext_wr_sel = esel; ext_wr_data = edata;
      tick();
      ext_wr_en = 1'b0;
      check({tag, " out_valid"}, 32'(out_valid), 32'd1);
      check({tag, " result"}, 32'(result), 32'(addend + 16'd1));
      tick();
   endtask

   initial begin
      int   low;
      logic early;

      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      check("reset in_ready", 32'(in_ready), 32'd1);
      check("reset out_valid", 32'(out_valid), 32'd0);
      check("reset result", 32'(result), 32'd0);
      check("reset flags", 32'(flags), 32'd0);

      ext_load(4'd1, 16'h7FFF);
      ext_load(4'd2, 16'h0001);
      ext_load(4'd8, 16'h0300);
      ext_load(4'd7, 16'h1234);

      drive(OP_ADD, 4'd3, 4'd1, 4'd2, 1'b0, 16'h0);
      accept("add");
      expect_out("add", 1, 1'b1, 16'h8000, FV | FN);

      drive(OP_SUB, 4'd4, 4'd2, 4'd2, 1'b0, 16'h0);
      accept("sub");
      expect_out("sub", 1, 1'b1, 16'h0000, FZ | FC);

      drive(OP_CMP, 4'd1, 4'd1, 4'd2, 1'b0, 16'h0);
      accept("cmp");
      expect_out("cmp", 1, 1'b0, 16'h0, FC);
      mov_check("cmp keeps r1", 4'd1, 16'h7FFF, 4'b0000);

      // Back-to-back: the second ADD reads R5 while it is still in the execute stage.
      drive(OP_ADD, 4'd5, 4'd1, 4'd2, 1'b0, 16'h0);
      accept("b2b first");
      drive(OP_ADD, 4'd6, 4'd5, 4'd2, 1'b0, 16'h0);
      accept("b2b second");
      check("b2b first out_valid", 32'(out_valid), 32'd1);
      check("b2b first result", 32'(result), 32'h8000);
      tick();
      check("b2b second out_valid", 32'(out_valid), 32'd1);
      check("b2b second result", 32'(result), 32'h8001);
      check("b2b second flags", 32'(flags), 32'(FN));
      tick();
      check("b2b pulse end", 32'(out_valid), 32'd0);

      // MUL R7 = 0x0300 * 0x0100 with a MOV R11 = R7 held at the issue port.
      drive(OP_MUL, 4'd7, 4'd8, 4'd0, 1'b1, 16'h0100);
      accept("mul");
      drive(OP_MOV, 4'd11, 4'd0, 4'd7, 1'b0, 16'h0);
      low   = 0;
      early = 1'b0;
      while (!in_ready && low < 40) begin
         early |= out_valid;
         low++;
         tick();
      end
      check("mul in_ready low cycles", 32'(low), 32'd16);
      check("mul early out_valid", 32'(early), 32'd0);
      check("mul out_valid", 32'(out_valid), 32'd1);
      check("mul result", 32'(result), 32'h0000);
      check("mul flags", 32'(flags), 32'(FC | FZ));
      accept("mul held issue");
      expect_out("mul held mov", 1, 1'b1, 16'h0000, FZ);

      ext_wr_en = 1'b1; ext_wr_sel = 4'd15; ext_wr_data = 16'h0055;
      drive(OP_ADD, 4'd0, 4'd15, 4'd0, 1'b1, 16'h0000);
      accept("ext fwd");
      ext_wr_en = 1'b0;
      expect_out("ext fwd", 1, 1'b1, 16'h0055, 4'b0000);

      collide("same reg", 4'd13, 16'h0005, 4'd13, 16'hBEEF);
      mov_check("same reg r13", 4'd13, 16'h0006, 4'b0000);
      collide("diff reg", 4'd9, 16'h0001, 4'd10, 16'h0A0A);
      mov_check("diff reg r9", 4'd9, 16'h0002, 4'b0000);
      mov_check("diff reg r10", 4'd10, 16'h0A0A, 4'b0000);

      drive(OP_SHL, 4'd1, 4'd1, 4'd0, 1'b1, 16'h0001);
      accept("shl");
      expect_out("shl", 1, 1'b1, 16'hFFFE, FN);

      drive(4'd12, 4'd3, 4'd1, 4'd2, 1'b0, 16'h0);
      accept("nop");
      expect_out("nop", 1, 1'b1, 16'hFFFE, FN);
      mov_check("nop keeps r3", 4'd3, 16'h8000, FN);

      // Reset five cycles into a multiply must abort it and clear all state.
      drive(OP_MUL, 4'd7, 4'd1, 4'd0, 1'b1, 16'h0003);
      accept("mul abort");
      repeat (5) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("midmul in_ready", 32'(in_ready), 32'd1);
      check("midmul out_valid", 32'(out_valid), 32'd0);
      check("midmul result", 32'(result), 32'd0);
      check("midmul flags", 32'(flags), 32'd0);
      early = 1'b0;
      repeat (20) begin
         early |= out_valid;
         tick();
      end
      check("midmul no late out_valid", 32'(early), 32'd0);
      mov_check("midmul r1 cleared", 4'd1, 16'h0000, FZ);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
